tdm_demux8: RTL and testbench

Receive-side time-division demultiplexer for the 8-channel, 3-bit datapath. A single shared bus carries one channel sample per valid beat, with slot 0 flagged by `frame_sync`. The block captures eight slots into a shadow buffer and presents them as eight parallel channel outputs. All eight outputs update together once per complete frame, and a one-cycle `frame_done` pulse marks each update.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_demux8_if.sv | 33 +++
 rtl/tdm_slot_ctr.sv | 41 ++++
 rtl/tdm_demux8.sv | 167 ++++++++++++++++
 tb/tb_tdm_demux8.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Constants and FSM encoding shared by the receive-side demux (tdm_demux8)
// and the transmit-side TDM mux.
//   TDM_SLOTS  : number of slots per frame
//   TDM_SLOT_W : sample width on the shared bus
//   TDM_CNT_W  : width of the slot counter
//   tdm_state_e: ST_HUNT (waiting for slot 0), ST_RECV (collecting 1..7)
// ---------------------------------------------------------------------------
package tdm_pkg;

    localparam int TDM_SLOTS  = 8;
    localparam int TDM_SLOT_W = 3;
    localparam int TDM_CNT_W  = 3;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux8_if.sv
// ---------------------------------------------------------------------------
// tdm_demux8_if
// Shared TDM bus carrying one slot sample per valid beat.
//   din        : slot sample
//   din_valid  : din carries a sample this cycle
//   frame_sync : qualified by din_valid, current beat is slot 0
// Modports:
//   master : drives the bus (transmitter / bench)
//   slave  : samples the bus (tdm_demux8)
// ---------------------------------------------------------------------------
interface tdm_demux8_if
    import tdm_pkg::*;
#(
    parameter int W = TDM_SLOT_W
) ();

    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;

    modport master (
        output din,
        output din_valid,
        output frame_sync
    );

    modport slave (
        input din,
        input din_valid,
        input frame_sync
    );

endinterface : tdm_demux8_if

// File: rtl/tdm_slot_ctr.sv
// ---------------------------------------------------------------------------
// tdm_slot_ctr
// Slot counter shared by the TDM mux and demux.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (counter -> 0)
//   load : sync beat, counter -> 1 (the sync beat itself is slot 0)
//   inc  : data beat, counter -> counter + 1 (7 wraps to 0)
//   slot : current slot index, i.e. the slot the next data beat fills
//   wrap : counter is 7, the next data beat completes the frame
// load has priority over inc.
// ---------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    output logic [TDM_CNT_W-1:0] slot,
    output logic                 wrap
);

    logic [TDM_CNT_W-1:0] slot_r;

    // Slot counter register: load-to-1 on sync, increment on a data beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r <= 3'd0;
        end else if (load) begin
            slot_r <= 3'd1;
        end else if (inc) begin
            slot_r <= slot_r + 3'd1;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;
    assign wrap = (slot_r == 3'd7);

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux8.sv
// ---------------------------------------------------------------------------
// tdm_demux8
// Receive-side 8-channel TDM demultiplexer. Slots 0..7 of a frame are
// collected into a shadow buffer; on the slot-7 beat all eight channel
// outputs are updated together and frame_done pulses for one cycle.
// A sync beat while a frame is in progress abandons the partial frame and
// restarts collection with that beat as slot 0.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   bus          : tdm_demux8_if.slave (din, din_valid, frame_sync)
//   Out0..Out7   : last complete frame, channel n = slot n (registered)
//   frame_done   : one-cycle pulse, Out0..Out7 updated this cycle
//   sync_err     : one-cycle pulse on premature sync or a beat dropped
//                  while hunting
//
// Optional feature macro: TDM_DEMUX_SYNC_CHECK_EN
//   defined   : sync_err detection logic is built
//   undefined : sync_err is tied to 0; frame capture is identical
// ---------------------------------------------------------------------------
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int W = TDM_SLOT_W
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux8_if.slave  bus,
    output logic [W-1:0] Out0,
    output logic [W-1:0] Out1,
    output logic [W-1:0] Out2,
    output logic [W-1:0] Out3,
    output logic [W-1:0] Out4,
    output logic [W-1:0] Out5,
    output logic [W-1:0] Out6,
    output logic [W-1:0] Out7,
    output logic         frame_done,
    output logic         sync_err
);

    tdm_state_e           state_r;
    tdm_state_e           state_nx_s;
    logic [TDM_CNT_W-1:0] slot_s;
    logic                 wrap_s;
    logic                 sync_beat_s;
    logic                 data_beat_s;
    logic                 recv_beat_s;
    logic                 last_s;
    logic [W-1:0]         sh_r  [TDM_SLOTS];
    logic [W-1:0]         out_r [TDM_SLOTS];
    logic                 frame_done_r;

    assign sync_beat_s = bus.din_valid & bus.frame_sync;
    assign data_beat_s = bus.din_valid & ~bus.frame_sync;
    // Data beats only count while a frame is open; in HUNT they are dropped.
    assign recv_beat_s = data_beat_s & (state_r == ST_RECV);
    assign last_s      = recv_beat_s & wrap_s;

    tdm_slot_ctr u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (sync_beat_s),
        .inc  (recv_beat_s),
        .slot (slot_s),
        .wrap (wrap_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: a sync beat always (re)opens a frame; slot 7 closes it.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_HUNT: begin
                if (sync_beat_s) begin
                    state_nx_s = ST_RECV;
                end else begin
                    state_nx_s = ST_HUNT;
                end
            end
            ST_RECV: begin
                if (sync_beat_s) begin
                    state_nx_s = ST_RECV;
                end else if (last_s) begin
                    state_nx_s = ST_HUNT;
                end else begin
                    state_nx_s = ST_RECV;
                end
            end
            default: begin
                state_nx_s = ST_HUNT;
            end
        endcase
    end

    // Shadow buffer: sync beat fills slot 0, data beats fill the counted slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TDM_SLOTS; i++) begin
                sh_r[i] <= {W{1'b0}};
            end
        end else if (sync_beat_s) begin
            sh_r[0] <= bus.din;
        end else if (recv_beat_s) begin
            sh_r[slot_s] <= bus.din;
        end else begin
            sh_r <= sh_r;
        end
    end

    // Output registers: slot 7 comes straight from the bus so the whole
    // frame appears on the same edge as its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TDM_SLOTS; i++) begin
                out_r[i] <= {W{1'b0}};
            end
            frame_done_r <= 1'b0;
        end else if (last_s) begin
            for (int i = 0; i < TDM_SLOTS - 1; i++) begin
                out_r[i] <= sh_r[i];
            end
            out_r[TDM_SLOTS-1] <= bus.din;
            frame_done_r       <= 1'b1;
        end else begin
            out_r        <= out_r;
            frame_done_r <= 1'b0;
        end
    end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic sync_err_r;

    // Error pulse: sync inside an open frame, or a data beat lost in HUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= (sync_beat_s & (state_r == ST_RECV)) |
                          (data_beat_s & (state_r == ST_HUNT));
        end
    end

    assign sync_err = sync_err_r;
`else
    assign sync_err = 1'b0;
`endif

    assign Out0       = out_r[0];
    assign Out1       = out_r[1];
    assign Out2       = out_r[2];
    assign Out3       = out_r[3];
    assign Out4       = out_r[4];
    assign Out5       = out_r[5];
    assign Out6       = out_r[6];
    assign Out7       = out_r[7];
    assign frame_done = frame_done_r;

endmodule : tdm_demux8

// File: tb/tb_tdm_demux8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux8
// Self-checking bench for tdm_demux8. A reference model keeps the open
// frame as a queue of samples; a full queue of eight becomes the expected
// output frame. Directed scenarios are followed by random traffic.
// Honours TDM_DEMUX_SYNC_CHECK_EN for the expected sync_err behaviour.
// ---------------------------------------------------------------------------
module tb_tdm_demux8;

    logic       clk;
    logic       rst;
    logic [2:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic       frame_done;
    logic       sync_err;
    logic [2:0] obs [8];

    int total;
    int bad;

    // reference model state
    logic [2:0] q [$];
    logic [2:0] exp_out [8];
    logic       exp_done;
    logic       exp_err;

    tdm_demux8_if #(.W(3)) bus ();

    tdm_demux8 #(.W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .Out0       (o0),
        .Out1       (o1),
        .Out2       (o2),
        .Out3       (o3),
        .Out4       (o4),
        .Out5       (o5),
        .Out6       (o6),
        .Out7       (o7),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    assign obs[0] = o0;
    assign obs[1] = o1;
    assign obs[2] = o2;
    assign obs[3] = o3;
    assign obs[4] = o4;
    assign obs[5] = o5;
    assign obs[6] = o6;
    assign obs[7] = o7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_outputs();
        for (int i = 0; i < 8; i++) begin
            total++;
            assert (obs[i] === exp_out[i]) else begin
                bad++;
                $error("FAIL out%0d: got %0d expected %0d", i, obs[i], exp_out[i]);
            end
        end
        total++;
        assert (frame_done === exp_done) else begin
            bad++;
            $error("FAIL frame_done: got %b expected %b", frame_done, exp_done);
        end
        total++;
        assert (sync_err === exp_err) else begin
            bad++;
            $error("FAIL sync_err: got %b expected %b", sync_err, exp_err);
        end
    endtask

    // one clock: drive inputs, advance the model, check after the edge
    task automatic step(input logic [2:0] d, input logic v, input logic s, input logic r);
        logic err_cond;
        bus.din        = d;
        bus.din_valid  = v;
        bus.frame_sync = s;
        rst            = r;
        @(posedge clk);
        err_cond = 1'b0;
        exp_done = 1'b0;
        if (r) begin
            q.delete();
            for (int i = 0; i < 8; i++) exp_out[i] = 3'd0;
        end else if (v) begin
            if (s) begin
                if (q.size() > 0) err_cond = 1'b1;
                q.delete();
                q.push_back(d);
            end else if (q.size() == 0) begin
                err_cond = 1'b1;
            end else begin
                q.push_back(d);
                if (q.size() == 8) begin
                    for (int i = 0; i < 8; i++) exp_out[i] = q[i];
                    exp_done = 1'b1;
                    q.delete();
                end
            end
        end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        exp_err = err_cond;
`else
        exp_err = 1'b0;
`endif
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] fdata [8];
        total    = 0;
        bad      = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < 8; i++) exp_out[i] = 3'd0;
        bus.din        = 3'd0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        rst            = 1'b1;

        // reset
        step(3'd0, 1'b0, 1'b0, 1'b1);
        step(3'd0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // clean frame 0..7
        step(3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) step(3'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            assert (obs[i] === 3'(i)) else begin
                bad++;
                $error("FAIL clean_frame out%0d: got %0d expected %0d", i, obs[i], i);
            end
        end
        idle(2);

        // gappy frame: reset outputs first so the hold-at-zero is visible
        step(3'd0, 1'b0, 1'b0, 1'b1);
        step(3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            idle(2);
            step(3'(i), 1'b1, 1'b0, 1'b0);
        end
        idle(2);

        // premature sync
        step(3'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) step(3'd5, 1'b1, 1'b0, 1'b0);
        step(3'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) step(3'd2, 1'b1, 1'b0, 1'b0);
        total++;
        assert (o0 === 3'd1 && o7 === 3'd2) else begin
            bad++;
            $error("FAIL premature: got out0=%0d out7=%0d expected 1 2", o0, o7);
        end
        idle(1);

        // back-to-back frames, second one reversed
        for (int i = 0; i < 16; i++) begin
            if (i < 8) step(3'(i), 1'b1, (i == 0), 1'b0);
            else       step(3'(15 - i), 1'b1, (i == 8), 1'b0);
        end
        total++;
        assert (o0 === 3'd7 && o7 === 3'd0) else begin
            bad++;
            $error("FAIL back2back: got out0=%0d out7=%0d expected 7 0", o0, o7);
        end
        idle(1);

        // hunt drop then clean frame
        for (int i = 0; i < 3; i++) step(3'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(3'(i), 1'b1, (i == 0), 1'b0);
        idle(1);

        // reset mid-frame after slot 4, then a clean frame
        for (int i = 0; i < 5; i++) step(3'd3, 1'b1, (i == 0), 1'b0);
        step(3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(3'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(3'(7 - i), 1'b1, (i == 0), 1'b0);
        idle(1);

        // random traffic: full random frames and noisy beats
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) fdata[i] = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                step(fdata[i], 1'b1, (i == 0), 1'b0);
            end
            for (int i = 0; i < 4; i++) begin
                step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0));
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tdm_demux8
